// File: rtl/intersection_scheduler.sv
// intersection_scheduler: two-approach right-of-way FSM with ped walk and emergency preempt
module intersection_scheduler #(
    parameter int T_MIN_GREEN = 4,
    parameter int T_MAX_GREEN = 10,
    parameter int T_YELLOW    = 2,
    parameter int T_ALL_RED   = 1,
    parameter int T_WALK      = 3,
    parameter int TW          = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       veh_a,
    input  logic       veh_b,
    input  logic       ped_a,
    input  logic       ped_b,
    input  logic       emg,
    input  logic       emg_dir,
    output logic [2:0] lights_a,
    output logic [2:0] lights_b,
    output logic       walk_a,
    output logic       walk_b,
    output logic [2:0] state_o
);
    typedef enum logic [2:0] {
        CLR_A = 3'd0,
        GRN_A = 3'd1,
        YEL_A = 3'd2,
        CLR_B = 3'd3,
        GRN_B = 3'd4,
        YEL_B = 3'd5
    } state_t;

    localparam logic [TW-1:0] AR_END  = TW'(T_ALL_RED - 1);
    localparam logic [TW-1:0] Y_END   = TW'(T_YELLOW - 1);
    localparam logic [TW-1:0] MIN_END = TW'(T_MIN_GREEN - 1);
    localparam logic [TW-1:0] MAX_END = TW'(T_MAX_GREEN - 1);
    localparam logic [TW-1:0] W_END   = TW'(T_WALK - 1);

    state_t        state, state_n;
    logic [TW-1:0] timer;
    logic          ped_lat_a, ped_lat_b;
    logic          req_a, req_b, emg_vs_a, emg_vs_b, enter_a, enter_b;

    assign req_a    = veh_a | ped_lat_a;
    assign req_b    = veh_b | ped_lat_b;
    assign emg_vs_a = emg & emg_dir;
    assign emg_vs_b = emg & ~emg_dir;
    assign enter_a  = (state_n == GRN_A) && (state != GRN_A);
    assign enter_b  = (state_n == GRN_B) && (state != GRN_B);

    always_comb begin
        state_n = state;
        case (state)
            CLR_A: if (tick && timer == AR_END) state_n = emg_vs_a ? CLR_B : GRN_A;
            GRN_A: if (emg_vs_a || (tick && !emg && req_b && timer >= MIN_END &&
                       (!veh_a || timer >= MAX_END))) state_n = YEL_A;
            YEL_A: if (tick && timer == Y_END) state_n = CLR_B;
            CLR_B: if (tick && timer == AR_END) state_n = emg_vs_b ? CLR_A : GRN_B;
            GRN_B: if (emg_vs_b || (tick && !emg && req_a && timer >= MIN_END &&
                       (!veh_b || timer >= MAX_END))) state_n = YEL_B;
            YEL_B: if (tick && timer == Y_END) state_n = CLR_A;
            default: state_n = CLR_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CLR_A;
            timer     <= '0;
            ped_lat_a <= 1'b0;
            ped_lat_b <= 1'b0;
            walk_a    <= 1'b0;
            walk_b    <= 1'b0;
        end else begin
            state     <= state_n;
            timer     <= (state_n != state) ? '0 : (tick && timer != '1) ? timer + 1'b1 : timer;
            ped_lat_a <= enter_a ? 1'b0 : ped_lat_a | ped_a;
            ped_lat_b <= enter_b ? 1'b0 : ped_lat_b | ped_b;
            // green timer doubles as walk timer since walk only starts on green entry
            walk_a    <= enter_a ? (ped_lat_a | ped_a) :
                         (state_n != GRN_A || (tick && timer == W_END)) ? 1'b0 : walk_a;
            walk_b    <= enter_b ? (ped_lat_b | ped_b) :
                         (state_n != GRN_B || (tick && timer == W_END)) ? 1'b0 : walk_b;
        end
    end

    always_comb begin
        lights_a = (state == GRN_A) ? 3'b001 : (state == YEL_A) ? 3'b010 : 3'b100;
        lights_b = (state == GRN_B) ? 3'b001 : (state == YEL_B) ? 3'b010 : 3'b100;
        state_o  = state;
    end
endmodule

// File: tb/tb_intersection_scheduler.sv
// tb_intersection_scheduler: directed checks of timing, pedestrian, emergency and reset behaviour
module tb_intersection_scheduler;
    logic       clk = 1'b0;
    logic       rst, tick, veh_a, veh_b, ped_a, ped_b, emg, emg_dir;
    logic [2:0] lights_a, lights_b, state_o;
    logic       walk_a, walk_b;
    int         n_chk = 0;
    int         n_bad = 0;
    bit         slow = 1'b0;
    int         phase = 0;

    intersection_scheduler dut (
        .clk(clk), .rst(rst), .tick(tick), .veh_a(veh_a), .veh_b(veh_b),
        .ped_a(ped_a), .ped_b(ped_b), .emg(emg), .emg_dir(emg_dir),
        .lights_a(lights_a), .lights_b(lights_b), .walk_a(walk_a), .walk_b(walk_b),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (slow) begin
            phase = (phase + 1) % 3;
            tick  = (phase == 0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1; tick = 1'b1; veh_a = 1'b0; veh_b = 1'b0;
        ped_a = 1'b0; ped_b = 1'b0; emg = 1'b0; emg_dir = 1'b0;
        step(); step();
        chk("rst_la", 8'(lights_a), 8'h4);
        chk("rst_lb", 8'(lights_b), 8'h4);
        chk("rst_st", 8'(state_o), 8'h0);
        chk("rst_wa", 8'(walk_a), 8'h0);
        rst = 1'b0;
        step();
        chk("rel_st", 8'(state_o), 8'h1);
        chk("rel_la", 8'(lights_a), 8'h1);
        chk("rel_lb", 8'(lights_b), 8'h4);
        repeat (50) step();
        chk("idle_hold", 8'(state_o), 8'h1);

        veh_a = 1'b1; veh_b = 1'b1;
        do_reset();
        repeat (9) step();
        chk("max_hold", 8'(state_o), 8'h1);
        step();
        chk("max_yel", 8'(state_o), 8'h2);
        chk("max_yel_la", 8'(lights_a), 8'h2);
        chk("max_yel_lb", 8'(lights_b), 8'h4);
        step();
        chk("yel_2", 8'(state_o), 8'h2);
        step();
        chk("clr_b", 8'(state_o), 8'h3);
        chk("clr_b_la", 8'(lights_a), 8'h4);
        step();
        chk("grn_b", 8'(state_o), 8'h4);
        chk("grn_b_lb", 8'(lights_b), 8'h1);
        chk("grn_b_la", 8'(lights_a), 8'h4);

        veh_a = 1'b0; veh_b = 1'b1;
        do_reset();
        repeat (3) step();
        chk("min_hold", 8'(state_o), 8'h1);
        step();
        chk("min_exit", 8'(state_o), 8'h2);

        do_reset();
        slow = 1'b1; phase = 0;
        repeat (9) step();
        chk("slow_hold", 8'(state_o), 8'h1);
        step();
        chk("slow_exit", 8'(state_o), 8'h2);
        slow = 1'b0; tick = 1'b1;

        do_reset();
        repeat (7) step();
        chk("ped_grn_b", 8'(state_o), 8'h4);
        ped_a = 1'b1;
        step();
        ped_a = 1'b0;
        repeat (8) step();
        chk("ped_b_hold", 8'(state_o), 8'h4);
        chk("ped_no_walk", 8'(walk_a), 8'h0);
        step();
        chk("ped_b_exit", 8'(state_o), 8'h5);
        step(); step();
        chk("ped_clr_a", 8'(state_o), 8'h0);
        step();
        chk("ped_grn_a", 8'(state_o), 8'h1);
        chk("walk_0", 8'(walk_a), 8'h1);
        step();
        chk("walk_1", 8'(walk_a), 8'h1);
        step();
        chk("walk_2", 8'(walk_a), 8'h1);
        step();
        chk("walk_end", 8'(walk_a), 8'h0);
        repeat (24) step();
        chk("lat_cleared", 8'(state_o), 8'h4);
        chk("walk_b_idle", 8'(walk_b), 8'h0);

        veh_a = 1'b0; veh_b = 1'b0;
        do_reset();
        step();
        emg = 1'b1; emg_dir = 1'b1;
        step();
        chk("emg_yel", 8'(state_o), 8'h2);
        chk("emg_yel_la", 8'(lights_a), 8'h2);
        step();
        chk("emg_yel2", 8'(state_o), 8'h2);
        step();
        chk("emg_clr_b", 8'(state_o), 8'h3);
        step();
        chk("emg_grn_b", 8'(state_o), 8'h4);
        veh_a = 1'b1;
        repeat (20) step();
        chk("emg_hold", 8'(state_o), 8'h4);
        emg = 1'b0;
        step();
        chk("emg_release", 8'(state_o), 8'h5);

        veh_a = 1'b0; ped_a = 1'b1;
        do_reset();
        chk("walk_direct", 8'(walk_a), 8'h1);
        ped_a = 1'b0; emg = 1'b1; emg_dir = 1'b1;
        step();
        chk("emg_walk_st", 8'(state_o), 8'h2);
        chk("emg_walk_clr", 8'(walk_a), 8'h0);
        emg = 1'b0;

        veh_a = 1'b0; veh_b = 1'b1;
        do_reset();
        repeat (6) step();
        chk("pre_clr_b", 8'(state_o), 8'h3);
        emg = 1'b1; emg_dir = 1'b0;
        step();
        chk("redir_clr_a", 8'(state_o), 8'h0);
        chk("redir_lb", 8'(lights_b), 8'h4);
        step();
        chk("redir_grn_a", 8'(state_o), 8'h1);
        emg = 1'b0;

        do_reset();
        repeat (7) step();
        veh_a = 1'b1; veh_b = 1'b0;
        repeat (4) step();
        chk("yel_b", 8'(state_o), 8'h5);
        rst = 1'b1;
        step();
        chk("mrst_st", 8'(state_o), 8'h0);
        chk("mrst_la", 8'(lights_a), 8'h4);
        chk("mrst_lb", 8'(lights_b), 8'h4);
        chk("mrst_wb", 8'(walk_b), 8'h0);
        rst = 1'b0;

        veh_a = 1'b0; veh_b = 1'b0; ped_a = 1'b1;
        do_reset();
        chk("wrst_pre", 8'(walk_a), 8'h1);
        ped_a = 1'b0; rst = 1'b1;
        step();
        chk("wrst_st", 8'(state_o), 8'h0);
        chk("wrst_wa", 8'(walk_a), 8'h0);
        rst = 1'b0;
        step();
        ped_a = 1'b1;
        step();
        ped_a = 1'b0;
        do_reset();
        chk("lat_rst", 8'(walk_a), 8'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
